// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - AES-128 key expansion sequencer, round-key cache and shared read port
// Steps key_block through rounds 0..NUM_ROUNDS, caches each round key, then serves enc/dec reads.
module key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int KB_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic [3:0]   kb_select,
  output logic [127:0] kb_in,
  input  logic [127:0] kb_round_key,
  input  logic         enc_req,
  input  logic [3:0]   enc_round,
  input  logic         dec_req,
  input  logic [3:0]   dec_round,
  output logic         enc_gnt,
  output logic         dec_gnt,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic         rk_owner,
  output logic         rk_err,
  output logic         ready
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [7:0] SETTLE_CYC = 8'(KB_LATENCY);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, READY} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   round_cnt;
  logic [7:0]   wait_cnt;
  logic         last_dec;
  logic         capture;
  logic         gnt_any;
  logic [3:0]   gnt_round;
  logic         gnt_bad;
  logic [127:0] mem [0:NUM_ROUNDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (key_load) begin
      state_nxt = SETTLE;
    end else begin
      case (state)
        SETTLE:  if (wait_cnt <= 8'd1) state_nxt = CAPTURE;
        CAPTURE: state_nxt = (round_cnt == LAST_ROUND) ? READY : SETTLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Tie-break favours whichever side did not win the previous grant.
  always_comb begin
    ready   = (state == READY);
    capture = (state == CAPTURE) && !key_load;
    enc_gnt = 1'b0;
    dec_gnt = 1'b0;
    if (state == READY && !key_load) begin
      if (enc_req && dec_req) begin
        enc_gnt = last_dec;
        dec_gnt = !last_dec;
      end else begin
        enc_gnt = enc_req;
        dec_gnt = dec_req && !enc_req;
      end
    end
  end

  assign gnt_any   = enc_gnt | dec_gnt;
  assign gnt_round = dec_gnt ? dec_round : enc_round;
  assign gnt_bad   = gnt_round > LAST_ROUND;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kb_in     <= '0;
      kb_select <= '0;
      round_cnt <= '0;
      wait_cnt  <= '0;
    end else if (key_load) begin
      kb_in     <= key_in;
      kb_select <= '0;
      round_cnt <= '0;
      wait_cnt  <= SETTLE_CYC;
    end else if (state == SETTLE && wait_cnt > 8'd1) begin
      wait_cnt <= wait_cnt - 8'd1;
    end else if (state == CAPTURE && round_cnt != LAST_ROUND) begin
      round_cnt <= round_cnt + 4'd1;
      kb_select <= round_cnt + 4'd1;
      wait_cnt  <= SETTLE_CYC;
    end
  end

  // Cache contents are don't-care until ready, so no reset.
  always_ff @(posedge clk) begin
    if (capture) mem[round_cnt] <= kb_round_key;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      rk_out   <= '0;
      rk_owner <= 1'b0;
      last_dec <= 1'b1;
    end else begin
      rk_valid <= gnt_any;
      rk_err   <= gnt_any && gnt_bad;
      rk_out   <= (gnt_any && !gnt_bad) ? mem[gnt_round] : '0;
      if (gnt_any) begin
        rk_owner <= dec_gnt;
        last_dec <= dec_gnt;
      end
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb/tb_key_sched_ctrl.sv - scoreboard bench for key_sched_ctrl with a stand-in key_block
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic [3:0]   kb_select;
  logic [127:0] kb_in;
  logic [127:0] kb_round_key;
  logic         enc_req, dec_req;
  logic [3:0]   enc_round, dec_round;
  logic         enc_gnt, dec_gnt, rk_valid, rk_owner, rk_err, ready;
  logic [127:0] rk_out;

  int checks = 0;
  int passes = 0;
  logic [129:0] exp_q[$];
  logic         exp_last_dec = 1'b1;
  logic [127:0] cur_key = '0;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;

  key_sched_ctrl dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .kb_select(kb_select), .kb_in(kb_in), .kb_round_key(kb_round_key),
    .enc_req(enc_req), .enc_round(enc_round), .dec_req(dec_req), .dec_round(dec_round),
    .enc_gnt(enc_gnt), .dec_gnt(dec_gnt), .rk_valid(rk_valid), .rk_out(rk_out),
    .rk_owner(rk_owner), .rk_err(rk_err), .ready(ready)
  );

  always #5 clk = ~clk;

  // Stand-in key_block: distinct key per round, one cycle of latency.
  function automatic logic [127:0] fake_rk(input logic [127:0] key, input logic [3:0] sel);
    return key ^ {16{4'h0, sel}};
  endfunction

  always @(posedge clk) kb_round_key <= fake_rk(kb_in, kb_select);

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Predict grants from the current requests and queue the expected response.
  task automatic arb_check();
    logic       ee, ed;
    logic [3:0] rd;
    ee = 1'b0;
    ed = 1'b0;
    if (enc_req && dec_req) begin
      if (exp_last_dec) ee = 1'b1;
      else ed = 1'b1;
    end else if (enc_req) ee = 1'b1;
    else if (dec_req) ed = 1'b1;
    #1;
    chk("gnt", {158'd0, enc_gnt, dec_gnt}, {158'd0, ee, ed});
    if (ee || ed) begin
      rd = ed ? dec_round : enc_round;
      exp_q.push_back({ed, rd > 4'd10, (rd > 4'd10) ? 128'd0 : fake_rk(cur_key, rd)});
      exp_last_dec = ed;
    end
  endtask

  task automatic step(input logic e, input logic [3:0] er, input logic d, input logic [3:0] dr);
    cycle();
    enc_req = e; enc_round = er; dec_req = d; dec_round = dr;
    arb_check();
  endtask

  always @(posedge clk) begin
    logic [129:0] e;
    #1;
    if (rst) begin
      if (exp_q.size() == 0) begin
        if (rk_valid) chk("rsp_unexpected", {159'd0, rk_valid}, 160'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", {159'd0, rk_valid}, 160'd1);
        chk("rsp", {30'd0, rk_owner, rk_err, rk_out}, {30'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic stray;
    rst = 1'b0; key_load = 1'b0; key_in = '0;
    enc_req = 1'b0; dec_req = 1'b0; enc_round = '0; dec_round = '0;
    repeat (2) cycle();
    chk("reset_kb", {28'd0, kb_select, kb_in}, 160'd0);
    chk("reset_out", {25'd0, rk_valid, rk_owner, rk_err, rk_out, ready, enc_gnt, dec_gnt}, 160'd0);

    // T1: reset in the middle of an expansion
    rst = 1'b1;
    cycle(); key_load = 1'b1; key_in = KEY1;
    cycle(); key_load = 1'b0;
    repeat (5) cycle();
    rst = 1'b0;
    #1;
    chk("midrst_kb", {28'd0, kb_select, kb_in}, 160'd0);
    chk("midrst_out", {25'd0, rk_valid, rk_owner, rk_err, rk_out, ready, enc_gnt, dec_gnt}, 160'd0);
    cycle(); rst = 1'b1;
    repeat (30) cycle();
    chk("no_ready_without_load", {159'd0, ready}, 160'd0);

    // T2: expansion of the all-zero key
    cycle(); key_load = 1'b1; key_in = '0; cur_key = '0;
    cycle(); key_load = 1'b0;
    chk("sel_e0", {156'd0, kb_select}, 160'd0);
    for (int k = 1; k <= 22; k++) begin
      cycle();
      chk($sformatf("sel_e%0d", k), {156'd0, kb_select}, (k < 22) ? 160'(k / 2) : 160'd10);
      chk($sformatf("ready_e%0d", k), {159'd0, ready}, (k == 22) ? 160'd1 : 160'd0);
    end

    // T3 single request, T4 contention, mem boundaries, T5 bad indices
    step(1'b1, 4'd3, 1'b0, 4'd0);
    step(1'b0, 4'd0, 1'b0, 4'd0);
    repeat (4) step(1'b1, 4'd5, 1'b1, 4'd7);
    step(1'b1, 4'd10, 1'b0, 4'd0);
    step(1'b0, 4'd0, 1'b1, 4'd0);
    step(1'b0, 4'd0, 1'b1, 4'd12);
    step(1'b1, 4'd11, 1'b0, 4'd0);
    step(1'b1, 4'd15, 1'b1, 4'd9);
    step(1'b1, 4'd1, 1'b1, 4'd10);

    // T6: reload in READY with enc still requesting
    cycle();
    key_load = 1'b1; key_in = KEY2; enc_req = 1'b1; enc_round = 4'd2; dec_req = 1'b0;
    #1;
    chk("gnt_on_load", {158'd0, enc_gnt, dec_gnt}, 160'd0);
    cur_key = KEY2;
    cycle(); key_load = 1'b0;
    chk("reload_ready_low", {159'd0, ready}, 160'd0);
    chk("reload_sel0", {156'd0, kb_select}, 160'd0);
    n = 0;
    stray = 1'b0;
    while (!ready && n < 60) begin
      #1;
      if (enc_gnt || dec_gnt) stray = 1'b1;
      cycle();
      n++;
    end
    chk("reload_edges", 160'(n), 160'd22);
    chk("no_gnt_loading", {159'd0, stray}, 160'd0);
    arb_check();
    step(1'b0, 4'd0, 1'b1, 4'd10);
    step(1'b0, 4'd0, 1'b0, 4'd0);
    repeat (3) cycle();
    chk("queue_drained", 160'(exp_q.size()), 160'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
